// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIB_W     : width of one adder slice pass
//   state_e   : sequencer states (encodings fixed; the unused code recovers to idle)
//   nib_count : number of slice passes needed for a given operand width
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : adder is computing or holding a result
// master = operand producer / result consumer, slave = the adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-look-ahead adder slice (purely combinational).
//   a, b  : nibble operands
//   cin   : carry in
//   sum   : nibble sum
//   carry : carry out of bit 3
module nibble_serial_adder_cla
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             carry
);
    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // All carries computed directly from g/p/cin, no rippling.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum   = p ^ c[NIB_W-1:0];
    assign carry = c[NIB_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CLA nibble slice is reused for WIDTH/4 passes, LSB first,
// with the carry kept in a register between passes. Result is held until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of nibble_serial_adder_if (operands in, sum/cout out, busy)
// WIDTH must match the interface WIDTH, be a multiple of 4 and at least 4.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int unsigned NIB   = nib_count(WIDTH);
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;

    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_carry;
    logic             last_nib;

    always_comb begin
        slice_a  = a_q[idx_q * NIB_W +: NIB_W];
        slice_b  = b_q[idx_q * NIB_W +: NIB_W];
        last_nib = (idx_q == IDX_W'(NIB - 1));
    end

    nibble_serial_adder_cla u_cla (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

    // A held result may be replaced in the same cycle it is consumed.
    assign bus.in_ready  = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StRun) | (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[idx_q * NIB_W +: NIB_W] <= slice_sum;
                    carry_q <= slice_carry;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_nib) begin
                        cout_q  <= slice_carry;
                        idx_q   <= '0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            carry_q <= bus.cin;
                            idx_q   <= '0;
                            state_q <= StRun;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
